// File: rtl/hazard_pkg.sv
// Shared types and limits for the pipeline hazard controller: FSM encoding,
// counter widths, the freeze timeout limit and the load-use match rule.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FREEZE  = 2'd1,
        ST_TIMEOUT = 2'd2
    } hz_state_t;

    localparam int CNT_W    = 16;
    localparam int FREEZE_W = 8;

    localparam logic [FREEZE_W-1:0] FREEZE_LIMIT = 8'd255;
    // TIMEOUT is entered on the edge where freeze_ctr steps onto the limit.
    localparam logic [FREEZE_W-1:0] FREEZE_LAST  = FREEZE_LIMIT - 8'd1;

    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       uses_rt
    );
        return mem_read && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: hazard inputs, pipeline
// enables/flushes and the status counters.
interface hazard_ctrl_if;
    import hazard_pkg::*;

    logic             ID_EX_MemRead;
    logic [4:0]       ID_EX_RegisterRt;
    logic [4:0]       IF_ID_RegisterRs;
    logic [4:0]       IF_ID_RegisterRt;
    logic             IF_ID_UsesRt;
    logic             EX_MEM_Branch_taken;
    logic             EX_MEM_Jump;
    logic             mem_busy;

    logic             PC_Write;
    logic             IF_ID_Write;
    logic             IF_Flush;
    logic             ID_Flush_lwstall;
    logic             ID_Flush_Branch;
    logic             EX_Flush;
    logic             Pipe_Hold;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             timeout_err;

    modport slave (
        input  ID_EX_MemRead, ID_EX_RegisterRt, IF_ID_RegisterRs, IF_ID_RegisterRt,
               IF_ID_UsesRt, EX_MEM_Branch_taken, EX_MEM_Jump, mem_busy,
        output PC_Write, IF_ID_Write, IF_Flush, ID_Flush_lwstall, ID_Flush_Branch,
               EX_Flush, Pipe_Hold, stall_cnt, flush_cnt, timeout_err
    );

    modport master (
        output ID_EX_MemRead, ID_EX_RegisterRt, IF_ID_RegisterRs, IF_ID_RegisterRt,
               IF_ID_UsesRt, EX_MEM_Branch_taken, EX_MEM_Jump, mem_busy,
        input  PC_Write, IF_ID_Write, IF_Flush, ID_Flush_lwstall, ID_Flush_Branch,
               EX_Flush, Pipe_Hold, stall_cnt, flush_cnt, timeout_err
    );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear wins over inc
// and the count sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory freeze with timeout, control flushes and
// load-use bubbles, plus saturating event counters.
//
// state      | meaning
// ST_RUN     | pipeline free-running, no memory wait in progress
// ST_FREEZE  | mem_busy held, freeze_ctr counting wait cycles
// ST_TIMEOUT | wait exceeded the limit, timeout_err raised, still frozen
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  bus
);

    hz_state_t            state;
    hz_state_t            state_next;
    logic [FREEZE_W-1:0]  freeze_ctr;
    logic [CNT_W-1:0]     stall_cnt;
    logic [CNT_W-1:0]     flush_cnt;
    logic                 timeout_err;

    logic freeze;
    logic ctrl_flush;
    logic load_use;
    logic stall_inc;
    logic flush_inc;
    logic freeze_inc;
    logic freeze_clr;

    assign freeze     = bus.mem_busy;
    assign ctrl_flush = bus.EX_MEM_Branch_taken | bus.EX_MEM_Jump;
    assign load_use   = load_use_hit(bus.ID_EX_MemRead, bus.ID_EX_RegisterRt,
                                     bus.IF_ID_RegisterRs, bus.IF_ID_RegisterRt,
                                     bus.IF_ID_UsesRt);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (bus.mem_busy) state_next = ST_FREEZE;
            end
            ST_FREEZE: begin
                if (!bus.mem_busy)               state_next = ST_RUN;
                else if (freeze_ctr >= FREEZE_LAST) state_next = ST_TIMEOUT;
            end
            ST_TIMEOUT: begin
                if (!bus.mem_busy) state_next = ST_RUN;
            end
            default: state_next = ST_RUN;
        endcase
    end

    // Outputs depend only on reset and live inputs, never on counter values.
    always_comb begin
        bus.PC_Write         = 1'b1;
        bus.IF_ID_Write      = 1'b1;
        bus.IF_Flush         = 1'b0;
        bus.ID_Flush_lwstall = 1'b0;
        bus.ID_Flush_Branch  = 1'b0;
        bus.EX_Flush         = 1'b0;
        bus.Pipe_Hold        = 1'b0;
        if (reset) begin
            bus.PC_Write         = 1'b0;
            bus.IF_ID_Write      = 1'b0;
            bus.IF_Flush         = 1'b1;
            bus.ID_Flush_lwstall = 1'b1;
            bus.ID_Flush_Branch  = 1'b1;
            bus.EX_Flush         = 1'b1;
        end else if (freeze) begin
            bus.PC_Write    = 1'b0;
            bus.IF_ID_Write = 1'b0;
            bus.Pipe_Hold   = 1'b1;
        end else if (ctrl_flush) begin
            bus.IF_Flush        = 1'b1;
            bus.ID_Flush_Branch = 1'b1;
            bus.EX_Flush        = 1'b1;
        end else if (load_use) begin
            bus.PC_Write         = 1'b0;
            bus.IF_ID_Write      = 1'b0;
            bus.ID_Flush_lwstall = 1'b1;
        end
    end

    assign stall_inc  = !reset && !freeze && !ctrl_flush && load_use;
    assign flush_inc  = !reset && !freeze && ctrl_flush;
    assign freeze_inc = (state == ST_FREEZE);
    assign freeze_clr = (state_next == ST_RUN);

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .clear (1'b0),
        .count (stall_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .clear (1'b0),
        .count (flush_cnt)
    );

    sat_counter #(.WIDTH(FREEZE_W)) u_freeze_ctr (
        .clk   (clk),
        .reset (reset),
        .inc   (freeze_inc),
        .clear (freeze_clr),
        .count (freeze_ctr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_err <= 1'b0;
        end else if ((state != ST_TIMEOUT) && (state_next == ST_TIMEOUT)) begin
            timeout_err <= 1'b1;
        end
    end

    assign bus.stall_cnt   = stall_cnt;
    assign bus.flush_cnt   = flush_cnt;
    assign bus.timeout_err = timeout_err;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed hazard scenarios plus random traffic checked
// against a cycle-level reference model of the hazard rules.
module tb_hazard_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    int   m_stall;
    int   m_flush;
    int   busy_run;
    bit   m_err;

    hazard_ctrl_if bus ();

    hazard_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Entered 1 time unit after a rising edge; leaves at the same phase one cycle later.
    task automatic step(input bit rst, input bit mr, input logic [4:0] ex_rt,
                        input logic [4:0] rs, input logic [4:0] id_rt, input bit ut,
                        input bit br, input bit jp, input bit busy);
        logic [6:0] exp_o;
        bit lu;
        bit cf;
        reset                   = rst;
        bus.ID_EX_MemRead       = mr;
        bus.ID_EX_RegisterRt    = ex_rt;
        bus.IF_ID_RegisterRs    = rs;
        bus.IF_ID_RegisterRt    = id_rt;
        bus.IF_ID_UsesRt        = ut;
        bus.EX_MEM_Branch_taken = br;
        bus.EX_MEM_Jump         = jp;
        bus.mem_busy            = busy;
        #4;
        lu = mr && (ex_rt != 0) && ((ex_rt == rs) || (ut && (ex_rt == id_rt)));
        cf = br || jp;
        // {PC_Write, IF_ID_Write, IF_Flush, ID_Flush_lwstall, ID_Flush_Branch, EX_Flush, Pipe_Hold}
        if (rst)       exp_o = 7'b0011110;
        else if (busy) exp_o = 7'b0000001;
        else if (cf)   exp_o = 7'b1110110;
        else if (lu)   exp_o = 7'b0001000;
        else           exp_o = 7'b1100000;
        chk("outputs", 32'({bus.PC_Write, bus.IF_ID_Write, bus.IF_Flush, bus.ID_Flush_lwstall,
                            bus.ID_Flush_Branch, bus.EX_Flush, bus.Pipe_Hold}), 32'(exp_o));
        @(posedge clk);
        #1;
        if (rst) begin
            m_stall  = 0;
            m_flush  = 0;
            busy_run = 0;
            m_err    = 0;
        end else begin
            if (!busy && !cf && lu && m_stall < 65535) m_stall++;
            if (!busy && cf && m_flush < 65535)        m_flush++;
            busy_run = busy ? busy_run + 1 : 0;
            if (busy_run >= 256) m_err = 1;
        end
        chk("stall_cnt", 32'(bus.stall_cnt), 32'(m_stall));
        chk("flush_cnt", 32'(bus.flush_cnt), 32'(m_flush));
        chk("timeout_err", 32'(bus.timeout_err), 32'(m_err));
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int stall_before;
        checks   = 0;
        failures = 0;
        m_stall  = 0;
        m_flush  = 0;
        busy_run = 0;
        m_err    = 0;
        reset    = 1'b1;
        bus.ID_EX_MemRead       = 1'b0;
        bus.ID_EX_RegisterRt    = '0;
        bus.IF_ID_RegisterRs    = '0;
        bus.IF_ID_RegisterRt    = '0;
        bus.IF_ID_UsesRt        = 1'b0;
        bus.EX_MEM_Branch_taken = 1'b0;
        bus.EX_MEM_Jump         = 1'b0;
        bus.mem_busy            = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        do_reset();
        chk("reset_stall", 32'(bus.stall_cnt), 32'd0);
        idle();

        // load-use on Rs
        step(0, 1, 5, 5, 0, 0, 0, 0, 0);
        chk("lu_stall_cnt", 32'(bus.stall_cnt), 32'd1);
        idle();

        // load to $0 never stalls
        step(0, 1, 0, 0, 0, 1, 0, 0, 0);
        chk("zero_pc_write", 32'(bus.PC_Write), 32'd1);
        // Rt match only counts when the ID instruction reads Rt
        step(0, 1, 7, 3, 7, 0, 0, 0, 0);
        step(0, 1, 7, 3, 7, 1, 0, 0, 0);

        // branch and load-use together
        do_reset();
        step(0, 1, 5, 5, 0, 0, 1, 0, 0);
        chk("br_flush_cnt", 32'(bus.flush_cnt), 32'd1);
        chk("br_stall_cnt", 32'(bus.stall_cnt), 32'd0);
        step(0, 1, 5, 5, 0, 0, 0, 1, 0);

        // freeze over a pending load-use, then a single bubble
        stall_before = m_stall;
        for (int i = 0; i < 3; i++) step(0, 1, 9, 9, 0, 0, 0, 0, 1);
        step(0, 1, 9, 9, 0, 0, 0, 0, 0);
        idle();
        chk("freeze_single_bubble", 32'(bus.stall_cnt), 32'(stall_before + 1));

        // long freeze reaches timeout
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, 1);
            if (i == 254) chk("timeout_before_256", 32'(bus.timeout_err), 32'd0);
            if (i == 255) chk("timeout_at_256", 32'(bus.timeout_err), 32'd1);
        end
        idle();
        idle();
        chk("timeout_sticky", 32'(bus.timeout_err), 32'd1);
        // a fresh short freeze after leaving TIMEOUT
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();

        // reset mid-freeze
        do_reset();
        for (int i = 0; i < 200; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        do_reset();
        for (int i = 0; i < 200; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("reset_mid_freeze", 32'(bus.timeout_err), 32'd0);
        idle();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(99) == 0, $urandom_range(1), 5'($urandom_range(3)),
                 5'($urandom_range(3)), 5'($urandom_range(3)), $urandom_range(1),
                 $urandom_range(7) == 0, $urandom_range(7) == 0, $urandom_range(4) == 0);
        end

        // stall counter saturation
        do_reset();
        for (int i = 0; i < 70000; i++) step(0, 1, 12, 12, 0, 0, 0, 0, 0);
        chk("stall_saturated", 32'(bus.stall_cnt), 32'h0000FFFF);
        do_reset();
        chk("sat_reset_stall", 32'(bus.stall_cnt), 32'd0);
        chk("sat_reset_flush", 32'(bus.flush_cnt), 32'd0);
        chk("sat_reset_err", 32'(bus.timeout_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
